// File: rtl/trap_ctrl_pkg.sv
// ============================================================================
//  trap_ctrl_pkg : shared trap/CSR types, addresses and cause encodings
//  Revision      : 1.0
// ============================================================================
`default_nettype none

package trap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_SAVE     = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_EXC  = 2'd1,
    KIND_IRQ  = 2'd2,
    KIND_RET  = 2'd3
  } kind_e;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

  localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
  localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

  // Bit positions inside the {MEIP, MTIP, MSIP} vectors
  localparam int IRQ_IDX_MSI = 0;
  localparam int IRQ_IDX_MTI = 1;
  localparam int IRQ_IDX_MEI = 2;

  localparam int MCAUSE_IRQ_BIT = 31;

  function automatic logic [31:0] make_mcause(input logic is_irq, input logic [3:0] code);
    logic [31:0] cause;
    cause                 = '0;
    cause[MCAUSE_IRQ_BIT] = is_irq;
    cause[3:0]            = code;
    return cause;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trap_ctrl_prio.sv
// ============================================================================
//  trap_prio : combinational event priority encoder (exception > irq > mret)
//  Revision  : 1.0
// ============================================================================
`default_nettype none

module trap_prio
  import trap_ctrl_pkg::*;
(
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_cause_i,
  input  logic [2:0]  irq_en_i,
  input  logic        mret_i,
  output logic        valid_o,
  output logic [1:0]  kind_o,
  output logic [31:0] cause_o
);

  always_comb begin
    valid_o = 1'b0;
    kind_o  = KIND_NONE;
    cause_o = '0;
    if (exc_valid_i) begin
      valid_o = 1'b1;
      kind_o  = KIND_EXC;
      cause_o = make_mcause(1'b0, exc_cause_i);
    end else if (|irq_en_i) begin
      valid_o = 1'b1;
      kind_o  = KIND_IRQ;
      // External beats software beats timer
      if (irq_en_i[IRQ_IDX_MEI]) begin
        cause_o = make_mcause(1'b1, IRQ_CODE_MEI);
      end else if (irq_en_i[IRQ_IDX_MSI]) begin
        cause_o = make_mcause(1'b1, IRQ_CODE_MSI);
      end else begin
        cause_o = make_mcause(1'b1, IRQ_CODE_MTI);
      end
    end else if (mret_i) begin
      valid_o = 1'b1;
      kind_o  = KIND_RET;
    end
  end

endmodule

`default_nettype wire

// File: rtl/trap_ctrl.sv
// ============================================================================
//  trap_ctrl : machine-mode trap sequencer (flush, CSR save, fetch redirect)
//  Revision  : 1.0
// ============================================================================
`default_nettype none

module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_cause_i,
  input  logic [31:0] exc_tval_i,
  input  logic [31:0] pc_i,
  input  logic [2:0]  irq_i,
  input  logic [2:0]  mie_i,
  input  logic        mstatus_mie_i,
  input  logic        mret_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        flush_o,
  output logic        busy_o,
  output logic        mepc_we_o,
  output logic [31:0] mepc_wdata_o,
  output logic        mcause_we_o,
  output logic [31:0] mcause_wdata_o,
  output logic        mtval_we_o,
  output logic [31:0] mtval_wdata_o,
  output logic        trap_enter_o,
  output logic        trap_exit_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e      state_q,  state_d;
  kind_e       kind_q,   kind_d;
  logic [3:0]  cnt_q,    cnt_d;
  logic [31:0] cause_q,  cause_d;
  logic [31:0] tval_q,   tval_d;
  logic [31:0] epc_q,    epc_d;
  logic [31:0] target_q, target_d;

  logic [2:0]  irq_en;
  logic        prio_valid;
  logic [1:0]  prio_kind;
  logic [31:0] prio_cause;
  logic        unused_lsbs;

  // Direct mode only: the low mode/alignment bits never reach the target
  assign unused_lsbs = ^{mtvec_i[1:0], mepc_i[1:0]};
  assign irq_en      = irq_i & mie_i & {3{mstatus_mie_i}};

  trap_prio u_prio (
    .exc_valid_i (exc_valid_i),
    .exc_cause_i (exc_cause_i),
    .irq_en_i    (irq_en),
    .mret_i      (mret_i),
    .valid_o     (prio_valid),
    .kind_o      (prio_kind),
    .cause_o     (prio_cause)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      kind_q   <= KIND_NONE;
      cnt_q    <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      epc_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
      epc_q    <= epc_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    tval_d   = tval_q;
    epc_d    = epc_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE: begin
        if (prio_valid) begin
          kind_d   = kind_e'(prio_kind);
          cause_d  = prio_cause;
          tval_d   = (prio_kind == KIND_EXC) ? exc_tval_i : 32'd0;
          epc_d    = pc_i;
          target_d = (prio_kind == KIND_RET) ? {mepc_i[31:2], 2'b00}
                                             : {mtvec_i[31:2], 2'b00};
          cnt_d    = FLUSH_LOAD;
          state_d  = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_SAVE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_SAVE: begin
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (redirect_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy_o           = (state_q != ST_IDLE);
    flush_o          = (state_q == ST_FLUSH);
    mepc_we_o        = 1'b0;
    mcause_we_o      = 1'b0;
    mtval_we_o       = 1'b0;
    trap_enter_o     = 1'b0;
    trap_exit_o      = 1'b0;
    mepc_wdata_o     = epc_q;
    mcause_wdata_o   = cause_q;
    mtval_wdata_o    = tval_q;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    if (state_q == ST_SAVE) begin
      if (kind_q == KIND_RET) begin
        trap_exit_o = 1'b1;
      end else begin
        mepc_we_o    = 1'b1;
        mcause_we_o  = 1'b1;
        mtval_we_o   = 1'b1;
        trap_enter_o = 1'b1;
      end
    end
    if (state_q == ST_REDIRECT) begin
      redirect_valid_o = 1'b1;
      redirect_pc_o    = target_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// ============================================================================
//  tb_trap_ctrl : vector table plus scoreboard bench for trap_ctrl
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_trap_ctrl;

  localparam int FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        exc_valid_i = 1'b0;
  logic [3:0]  exc_cause_i = '0;
  logic [31:0] exc_tval_i = '0;
  logic [31:0] pc_i = '0;
  logic [2:0]  irq_i = '0;
  logic [2:0]  mie_i = '0;
  logic        mstatus_mie_i = 1'b0;
  logic        mret_i = 1'b0;
  logic [31:0] mtvec_i = '0;
  logic [31:0] mepc_i = '0;
  logic        redirect_ready_i = 1'b1;
  logic        flush_o, busy_o, mepc_we_o, mcause_we_o, mtval_we_o;
  logic        trap_enter_o, trap_exit_o, redirect_valid_o;
  logic [31:0] mepc_wdata_o, mcause_wdata_o, mtval_wdata_o, redirect_pc_o;

  trap_ctrl #(.FLUSH_CYCLES(FLUSH)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .exc_valid_i      (exc_valid_i),
    .exc_cause_i      (exc_cause_i),
    .exc_tval_i       (exc_tval_i),
    .pc_i             (pc_i),
    .irq_i            (irq_i),
    .mie_i            (mie_i),
    .mstatus_mie_i    (mstatus_mie_i),
    .mret_i           (mret_i),
    .mtvec_i          (mtvec_i),
    .mepc_i           (mepc_i),
    .flush_o          (flush_o),
    .busy_o           (busy_o),
    .mepc_we_o        (mepc_we_o),
    .mepc_wdata_o     (mepc_wdata_o),
    .mcause_we_o      (mcause_we_o),
    .mcause_wdata_o   (mcause_wdata_o),
    .mtval_we_o       (mtval_we_o),
    .mtval_wdata_o    (mtval_wdata_o),
    .trap_enter_o     (trap_enter_o),
    .trap_exit_o      (trap_exit_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ready_i (redirect_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exc;
    logic [3:0]  cause;
    logic [31:0] tval;
    logic [31:0] pc;
    logic [2:0]  irq;
    logic [2:0]  mie;
    logic        gmie;
    logic        mret;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        acc;
    logic        ret;
    logic [31:0] e_mepc;
    logic [31:0] e_mcause;
    logic [31:0] e_mtval;
    logic [31:0] e_target;
  } vec_t;

  typedef struct {
    logic        is_ret;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] target;
  } sb_t;

  int   checks = 0;
  int   errors = 0;
  sb_t  sb[$];
  logic save_seen = 1'b0;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic exc, input logic [3:0] cause, input logic [31:0] tval,
                              input logic [31:0] pc, input logic [2:0] irq, input logic [2:0] mie,
                              input logic gmie, input logic mret, input logic [31:0] mtvec,
                              input logic [31:0] mepc, input logic acc, input logic ret,
                              input logic [31:0] e_mepc, input logic [31:0] e_mcause,
                              input logic [31:0] e_mtval, input logic [31:0] e_target);
    vec_t v;
    v.exc = exc;  v.cause = cause; v.tval = tval; v.pc = pc;
    v.irq = irq;  v.mie = mie;     v.gmie = gmie; v.mret = mret;
    v.mtvec = mtvec; v.mepc = mepc; v.acc = acc;  v.ret = ret;
    v.e_mepc = e_mepc; v.e_mcause = e_mcause; v.e_mtval = e_mtval; v.e_target = e_target;
    return v;
  endfunction

  // Strobe data checked against the head entry; popped on the redirect handshake
  always @(negedge clk) begin
    if (rst_i) begin
      if (mepc_we_o || trap_exit_o) begin
        if (sb.size() == 0) begin
          check("spurious_strobe", 32'd1, 32'd0);
        end else if (save_seen) begin
          check("repeat_strobe", 32'd1, 32'd0);
        end else begin
          save_seen = 1'b1;
          if (sb[0].is_ret) begin
            check("ret_exit", {31'd0, trap_exit_o}, 32'd1);
            check("ret_no_we", {29'd0, mepc_we_o, mcause_we_o, mtval_we_o}, 32'd0);
            check("ret_no_enter", {31'd0, trap_enter_o}, 32'd0);
          end else begin
            check("trap_we", {29'd0, mepc_we_o, mcause_we_o, mtval_we_o}, 32'd7);
            check("trap_enter", {31'd0, trap_enter_o}, 32'd1);
            check("trap_no_exit", {31'd0, trap_exit_o}, 32'd0);
            check("mepc_wdata", mepc_wdata_o, sb[0].mepc);
            check("mcause_wdata", mcause_wdata_o, sb[0].mcause);
            check("mtval_wdata", mtval_wdata_o, sb[0].mtval);
          end
        end
      end
      if (redirect_valid_o && redirect_ready_i) begin
        if (sb.size() == 0) begin
          check("spurious_redirect", 32'd1, 32'd0);
        end else begin
          check("redirect_pc", redirect_pc_o, sb[0].target);
          check("save_before_redirect", {31'd0, save_seen}, 32'd1);
          void'(sb.pop_front());
          save_seen = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    exc_valid_i   = v.exc;
    exc_cause_i   = v.cause;
    exc_tval_i    = v.tval;
    pc_i          = v.pc;
    irq_i         = v.irq;
    mie_i         = v.mie;
    mstatus_mie_i = v.gmie;
    mret_i        = v.mret;
    mtvec_i       = v.mtvec;
    mepc_i        = v.mepc;
  endtask

  task automatic clear_ev();
    exc_valid_i = 1'b0;
    irq_i       = '0;
    mret_i      = 1'b0;
  endtask

  task automatic push(input vec_t v);
    sb_t e;
    e.is_ret = v.ret;
    e.mepc   = v.e_mepc;
    e.mcause = v.e_mcause;
    e.mtval  = v.e_mtval;
    e.target = v.e_target;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flush"}, {31'd0, flush_o}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_we"}, {27'd0, mepc_we_o, mcause_we_o, mtval_we_o, trap_enter_o, trap_exit_o}, 32'd0);
    check({tag, "_rvalid"}, {31'd0, redirect_valid_o}, 32'd0);
    check({tag, "_rpc"}, redirect_pc_o, 32'd0);
    check({tag, "_wdata"}, mepc_wdata_o | mcause_wdata_o | mtval_wdata_o, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int stall);
    redirect_ready_i = (stall == 0);
    drive(v);
    tick();
    clear_ev();
    if (!v.acc) begin
      check("no_accept_busy", {31'd0, busy_o}, 32'd0);
      check("no_accept_flush", {31'd0, flush_o}, 32'd0);
      return;
    end
    push(v);
    for (int j = 0; j < FLUSH; j++) begin
      check("flush_hi", {31'd0, flush_o}, 32'd1);
      check("busy_flush", {31'd0, busy_o}, 32'd1);
      tick();
    end
    check("save_strobe", {31'd0, mepc_we_o | trap_exit_o}, 32'd1);
    check("save_no_flush", {31'd0, flush_o}, 32'd0);
    tick();
    check("redirect_valid", {31'd0, redirect_valid_o}, 32'd1);
    check("busy_redirect", {31'd0, busy_o}, 32'd1);
    for (int j = 0; j < stall; j++) begin
      check("stall_valid", {31'd0, redirect_valid_o}, 32'd1);
      check("stall_pc", redirect_pc_o, v.e_target);
      check("stall_no_strobe", {29'd0, mepc_we_o, trap_enter_o, trap_exit_o}, 32'd0);
      exc_valid_i = (j % 2 == 0);
      tick();
    end
    exc_valid_i      = 1'b0;
    redirect_ready_i = 1'b1;
    tick();
    check("idle_after_hs", {31'd0, busy_o}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            exc cause tval          pc            irq     mie     gm mret mtvec         mepc          acc ret e_mepc        e_mcause      e_mtval       e_target
    vecs[0]  = mk(1, 4'd2,  32'hDEAD,     32'h100,      3'b000, 3'b000, 0, 0, 32'h8000_0003, 32'h0,        1, 0, 32'h100,      32'h2,        32'hDEAD,     32'h8000_0000);
    vecs[1]  = mk(0, 4'd0,  32'h55,       32'h200,      3'b110, 3'b111, 1, 0, 32'h8000_0003, 32'h0,        1, 0, 32'h200,      32'h8000_000B, 32'h0,       32'h8000_0000);
    vecs[2]  = mk(0, 4'd0,  32'h0,        32'h204,      3'b110, 3'b111, 0, 0, 32'h8000_0003, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0);
    vecs[3]  = mk(0, 4'd0,  32'h0,        32'h208,      3'b000, 3'b111, 1, 1, 32'h8000_0003, 32'h2004,     1, 1, 32'h0,        32'h0,        32'h0,        32'h2004);
    vecs[4]  = mk(1, 4'd5,  32'h1234,     32'h300,      3'b111, 3'b111, 1, 1, 32'h8000_0003, 32'h2004,     1, 0, 32'h300,      32'h5,        32'h1234,     32'h8000_0000);
    vecs[5]  = mk(0, 4'd0,  32'h0,        32'h400,      3'b011, 3'b111, 1, 0, 32'h8000_0003, 32'h0,        1, 0, 32'h400,      32'h8000_0003, 32'h0,       32'h8000_0000);
    vecs[6]  = mk(0, 4'd0,  32'h0,        32'h404,      3'b010, 3'b111, 1, 0, 32'h8000_0003, 32'h0,        1, 0, 32'h404,      32'h8000_0007, 32'h0,       32'h8000_0000);
    vecs[7]  = mk(0, 4'd0,  32'h0,        32'h408,      3'b111, 3'b011, 1, 0, 32'h8000_0003, 32'h0,        1, 0, 32'h408,      32'h8000_0003, 32'h0,       32'h8000_0000);
    vecs[8]  = mk(0, 4'd0,  32'h0,        32'h40C,      3'b100, 3'b011, 1, 0, 32'h8000_0003, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0);
    vecs[9]  = mk(0, 4'd0,  32'h0,        32'h410,      3'b100, 3'b011, 1, 1, 32'h8000_0003, 32'h400B,     1, 1, 32'h0,        32'h0,        32'h0,        32'h4008);
    vecs[10] = mk(1, 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 3'b000, 3'b000, 0, 0, 32'h1235,    32'h0,        1, 0, 32'hFFFF_FFFC, 32'hF,       32'hFFFF_FFFF, 32'h1234);

    #2 rst_i = 1'b0;
    #1 check_all_zero("reset");
    tick();
    tick();
    #2 rst_i = 1'b1;
    tick();
    check("idle_after_reset", {31'd0, busy_o}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], 0);
    end

    // Redirect stalled for 5 cycles with exceptions arriving meanwhile
    run_vec(vecs[0], 5);

    // Reset while flushing
    redirect_ready_i = 1'b1;
    drive(vecs[0]);
    tick();
    clear_ev();
    push(vecs[0]);
    check("pre_rst_flush", {31'd0, flush_o}, 32'd1);
    #2 rst_i = 1'b0;
    #1 check_all_zero("rst_in_flush");
    sb.delete();
    save_seen = 1'b0;
    tick();
    check_all_zero("rst_held");
    #2 rst_i = 1'b1;
    tick();
    run_vec(vecs[10], 0);

    // Reset while waiting on the redirect handshake
    redirect_ready_i = 1'b0;
    drive(vecs[1]);
    tick();
    clear_ev();
    push(vecs[1]);
    for (int j = 0; j < FLUSH + 1; j++) tick();
    check("pre_rst_rvalid", {31'd0, redirect_valid_o}, 32'd1);
    #2 rst_i = 1'b0;
    #1 check_all_zero("rst_in_redirect");
    sb.delete();
    save_seen = 1'b0;
    tick();
    #2 rst_i = 1'b1;
    redirect_ready_i = 1'b1;
    tick();
    run_vec(vecs[4], 0);

    check("sb_final_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
